// File: rtl/rand_pair_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rand_pair_gen                                                |
// | Description : LFSR-driven operand pair source for the OR/AND output stage. |
// |               Each run emits NUM_VECT vectors on a/b, each held for        |
// |               HOLD_CYC clocks, with a valid pulse on every new vector.     |
// | Ports       : clk, rst        clock, async active-high reset               |
// |               start           begin a run (only honoured in IDLE)          |
// |               stop            abort a run (only honoured in RUN)           |
// |               seed_load       load seed_in into the LFSR (IDLE only)       |
// |               seed_in         new seed; zero selects SEED                  |
// |               a, b            registered operand pair                      |
// |               valid           1-clk pulse when a/b change to a new vector  |
// |               busy            high while a run is in progress              |
// |               done            1-clk pulse on normal run completion         |
// |               vect_cnt        vectors emitted in the current/last run      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rand_pair_gen #(
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
  parameter int                HOLD_CYC = 10,
  parameter int                NUM_VECT = 20
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              seed_load,
  input  logic [LFSR_W-1:0]                 seed_in,
  output logic                              a,
  output logic                              b,
  output logic                              valid,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(NUM_VECT+1)-1:0]     vect_cnt
);

  // Hold counter needs at least one bit even when HOLD_CYC == 1.
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int VW = $clog2(NUM_VECT + 1);

  localparam logic [HW-1:0] c_hold_last = HW'(HOLD_CYC - 1);
  localparam logic [VW-1:0] c_num_vect  = VW'(NUM_VECT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state,    w_state_nxt;
  logic [LFSR_W-1:0] r_lfsr,     w_lfsr_nxt;
  logic [HW-1:0]     r_hold_cnt, w_hold_nxt;
  logic [VW-1:0]     r_vect_cnt, w_vect_nxt;
  logic              r_a,        w_a_nxt;
  logic              r_b,        w_b_nxt;
  logic              r_valid,    w_valid_nxt;
  logic              r_busy,     w_busy_nxt;
  logic              r_done,     w_done_nxt;

  logic [LFSR_W-1:0] w_lfsr_step;

  // Galois right-shift step: feedback mask applied when the bit shifted out is 1.
  assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_hold_nxt  = r_hold_cnt;
    w_vect_nxt  = r_vect_cnt;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // seed_load wins over start so a reseed never launches a run.
        if (seed_load) begin
          w_lfsr_nxt = (seed_in == '0) ? SEED : seed_in;
        end else if (start) begin
          w_a_nxt     = r_lfsr[0];
          w_b_nxt     = r_lfsr[1];
          w_lfsr_nxt  = w_lfsr_step;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_vect_nxt  = VW'(1);
          w_hold_nxt  = '0;
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        if (stop) begin
          // Abort: lfsr and vect_cnt are left untouched so a later run
          // carries on with the same pseudo-random sequence.
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_hold_nxt  = '0;
        end else if (r_hold_cnt == c_hold_last) begin
          w_hold_nxt = '0;
          if (r_vect_cnt < c_num_vect) begin
            w_a_nxt     = r_lfsr[0];
            w_b_nxt     = r_lfsr[1];
            w_lfsr_nxt  = w_lfsr_step;
            w_valid_nxt = 1'b1;
            w_vect_nxt  = r_vect_cnt + 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= SEED;
      r_hold_cnt <= '0;
      r_vect_cnt <= '0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lfsr     <= w_lfsr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_vect_cnt <= w_vect_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign a        = r_a;
  assign b        = r_b;
  assign valid    = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign vect_cnt = r_vect_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rand_pair_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rand_pair_gen                                             |
// | Description : Self-checking bench for rand_pair_gen. A timeline model      |
// |               (cycles elapsed since start) predicts every output each      |
// |               clock; directed scenarios plus randomized control traffic.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_rand_pair_gen;

  localparam int          c_h    = 10;
  localparam int          c_n    = 20;
  localparam logic [15:0] c_seed = 16'hACE1;
  localparam logic [15:0] c_taps = 16'hB400;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, seed_load;
  logic [15:0] seed_in;
  logic        a, b, valid, busy, done;
  logic [4:0]  vect_cnt;

  logic        start2;
  logic        a2, b2, valid2, busy2, done2;
  logic [0:0]  vect_cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int n_valid_seen, n_busy_seen, n_done_seen;

  // model state
  bit          m_busy;
  int          m_n;
  logic [15:0] m_lfsr;
  logic        m_a, m_b, m_valid, m_done;
  int          m_vect;

  always #5 clk = ~clk;

  rand_pair_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .seed_load(seed_load), .seed_in(seed_in),
    .a(a), .b(b), .valid(valid), .busy(busy), .done(done), .vect_cnt(vect_cnt)
  );

  rand_pair_gen #(.HOLD_CYC(1), .NUM_VECT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(1'b0),
    .seed_load(1'b0), .seed_in(16'h0000),
    .a(a2), .b(b2), .valid(valid2), .busy(busy2), .done(done2), .vect_cnt(vect_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? c_taps : 16'h0000);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_n = 0; m_lfsr = c_seed;
    m_a = 0; m_b = 0; m_valid = 0; m_done = 0; m_vect = 0;
  endtask

  task automatic model_emit();
    m_a     = m_lfsr[0];
    m_b     = m_lfsr[1];
    m_lfsr  = lfsr_next(m_lfsr);
    m_valid = 1;
  endtask

  // One clock edge of the reference: a run is a timeline of N*H clocks,
  // vector k starting at clock (k-1)*H after the start edge.
  task automatic model_edge(input logic st, input logic sp, input logic sl, input logic [15:0] si);
    m_valid = 0;
    m_done  = 0;
    if (!m_busy) begin
      if (sl) m_lfsr = (si == 16'h0000) ? c_seed : si;
      else if (st) begin
        m_busy = 1; m_n = 0; m_vect = 1;
        model_emit();
      end
    end else begin
      m_n++;
      if (sp) m_busy = 0;
      else if (m_n == c_n * c_h) begin
        m_busy = 0; m_done = 1;
      end else if (m_n % c_h == 0) begin
        m_vect = m_n / c_h + 1;
        model_emit();
      end
    end
  endtask

  task automatic check_all();
    chk("a",        32'(a),        32'(m_a));
    chk("b",        32'(b),        32'(m_b));
    chk("valid",    32'(valid),    32'(m_valid));
    chk("busy",     32'(busy),     32'(m_busy));
    chk("done",     32'(done),     32'(m_done));
    chk("vect_cnt", 32'(vect_cnt), 32'(m_vect));
  endtask

  task automatic cycle(input logic st, input logic sp, input logic sl, input logic [15:0] si);
    start = st; stop = sp; seed_load = sl; seed_in = si;
    @(posedge clk);
    model_edge(st, sp, sl, si);
    #1;
    check_all();
    if (valid) n_valid_seen++;
    if (busy)  n_busy_seen++;
    if (done)  n_done_seen++;
    start = 0; stop = 0; seed_load = 0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 16'h0000);
  endtask

  task automatic clear_counts();
    n_valid_seen = 0; n_busy_seen = 0; n_done_seen = 0;
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; seed_load = 0; seed_in = 0; start2 = 0;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_busy2", 32'(busy2), 0);
    rst = 0;

    // 1/2: first vectors and a full default run
    clear_counts();
    cycle(1, 0, 0, 16'h0000);
    chk("t1_a1", 32'(a), 1);
    chk("t1_b1", 32'(b), 0);
    idle(9);
    cycle(0, 0, 0, 16'h0000);
    chk("t1_a2", 32'(a), 0);
    chk("t1_b2", 32'(b), 0);
    chk("t1_valid2", 32'(valid), 1);
    idle(189);
    cycle(0, 0, 0, 16'h0000);            // edge E0+200
    chk("t2_done", 32'(done), 1);
    chk("t2_vcnt", 32'(vect_cnt), 20);
    chk("t2_nvalid", 32'(n_valid_seen), 20);
    chk("t2_nbusy", 32'(n_busy_seen), 200);
    idle(3);
    chk("t2_ndone", 32'(n_done_seen), 1);

    // 3: stop at E0+35
    clear_counts();
    cycle(1, 0, 0, 16'h0000);
    idle(34);
    cycle(0, 1, 0, 16'h0000);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_vcnt", 32'(vect_cnt), 4);
    idle(30);
    chk("t3_ndone", 32'(n_done_seen), 0);
    cycle(1, 0, 0, 16'h0000);
    chk("t3_restart_vcnt", 32'(vect_cnt), 1);
    idle(5);
    cycle(0, 1, 0, 16'h0000);

    // 4: seed loading
    cycle(0, 0, 1, 16'h0000);
    cycle(1, 0, 0, 16'h0000);
    chk("t4_seed0_a", 32'(a), 1);
    chk("t4_seed0_b", 32'(b), 0);
    cycle(0, 1, 0, 16'h0000);
    cycle(0, 0, 1, 16'h0001);
    cycle(1, 0, 0, 16'h0000);
    chk("t4_seed1_a", 32'(a), 1);
    chk("t4_seed1_b", 32'(b), 0);
    idle(4);
    cycle(0, 0, 1, 16'h1234);            // ignored while running
    idle(4);
    cycle(0, 0, 0, 16'h0000);            // vector 2 from 0xB400
    chk("t4_b400_a", 32'(a), 0);
    chk("t4_b400_b", 32'(b), 0);
    chk("t4_b400_v", 32'(valid), 1);
    cycle(0, 1, 0, 16'h0000);

    // 5: start+seed_load together, start during RUN
    cycle(1, 0, 1, 16'h00F3);
    chk("t5_nobusy", 32'(busy), 0);
    chk("t5_novalid", 32'(valid), 0);
    clear_counts();
    cycle(1, 0, 0, 16'h0000);
    chk("t5_a", 32'(a), 1);
    chk("t5_b", 32'(b), 1);
    for (int i = 1; i < 200; i++) cycle((i % 7) == 0, 0, 0, 16'h0000);
    cycle(1, 0, 0, 16'h0000);            // edge E0+200 with start high
    chk("t5_done", 32'(done), 1);
    chk("t5_nvalid", 32'(n_valid_seen), 20);

    // 6: asynchronous reset mid-run
    cycle(1, 0, 0, 16'h0000);
    idle(57);
    #2 rst = 1;
    #1;
    chk("t6_a", 32'(a), 0);
    chk("t6_b", 32'(b), 0);
    chk("t6_valid", 32'(valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_vcnt", 32'(vect_cnt), 0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 0;
    cycle(1, 0, 0, 16'h0000);
    chk("t6_seed_a", 32'(a), 1);
    chk("t6_seed_b", 32'(b), 0);
    cycle(0, 1, 0, 16'h0000);

    // HOLD_CYC=1, NUM_VECT=1 instance
    start2 = 1;
    cycle(0, 0, 0, 16'h0000);
    chk("h1_valid", 32'(valid2), 1);
    chk("h1_busy", 32'(busy2), 1);
    chk("h1_vcnt", 32'(vect_cnt2), 1);
    chk("h1_a", 32'(a2), 1);
    start2 = 0;
    cycle(0, 0, 0, 16'h0000);
    chk("h1_done", 32'(done2), 1);
    chk("h1_valid_off", 32'(valid2), 0);
    chk("h1_busy_off", 32'(busy2), 0);
    cycle(0, 0, 0, 16'h0000);
    chk("h1_done_off", 32'(done2), 0);

    // randomized control traffic
    for (int i = 0; i < 3000; i++) begin
      logic        rs, rp, rl;
      logic [15:0] rv;
      rs = ($urandom_range(0, 19) == 0);
      rp = ($urandom_range(0, 149) == 0);
      rl = ($urandom_range(0, 29) == 0);
      rv = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      cycle(rs, rp, rl, rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
